uart_port_scheduler: RTL and testbench

- Shares the single half-duplex UART core between N_REQ byte producers and one receive consumer.
- Arbitrates transmit requests round-robin and sequences the core's enables: tx_enable pulse, then wait for busy, then wait for done, then guard time.
- Holds rx_enable low while a transmit is in flight.
- Sits between application logic and the uart instance in the top level.

---
 rtl/uart_port_scheduler_pkg.sv | 25 ++
 rtl/uart_port_scheduler_rr_arbiter.sv | 32 +++
 rtl/uart_port_scheduler.sv | 151 +++++++++++++++
 tb/tb_uart_port_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_port_scheduler_pkg.sv
// Shared types and constants for the UART port scheduler.
`timescale 1ns/1ps
package uart_port_scheduler_pkg;

   localparam int unsigned UART_BYTE_W          = 8;
   localparam int unsigned CLK_HZ               = 12_000_000;
   localparam int unsigned BAUD                 = 115_200;
   // One bit time of idle line between bytes (104 clocks at 12 MHz / 115200)
   localparam int unsigned DEFAULT_GUARD_CYCLES = CLK_HZ / BAUD;
   localparam int unsigned DEFAULT_BUSY_TIMEOUT = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_BUSY,
      SEND,
      GUARD
   } uart_sched_state_t;

   // Counter width able to hold the larger of two terminal counts
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

endpackage

// File: rtl/uart_port_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr, wrapping.
`timescale 1ns/1ps
module uart_port_scheduler_rr_arbiter #(
   parameter int unsigned N_REQ = 4,
   localparam int unsigned PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] winner_c,
   output logic [PTR_W-1:0] idx_c,
   output logic             valid_c
);

   logic [PTR_W-1:0] pos;

   // Scan N_REQ positions starting at rr_ptr; first hit wins
   always_comb begin
      winner_c = '0;
      idx_c    = '0;
      valid_c  = 1'b0;
      pos      = '0;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         pos = PTR_W'((32'(rr_ptr) + off) % N_REQ);
         if (!valid_c && req[pos]) begin
            valid_c       = 1'b1;
            winner_c[pos] = 1'b1;
            idx_c         = pos;
         end
      end
   end

endmodule

// File: rtl/uart_port_scheduler.sv
// Shares one half-duplex UART core between N_REQ byte producers and the RX consumer.
`timescale 1ns/1ps
module uart_port_scheduler
   import uart_port_scheduler_pkg::*;
#(
   parameter int unsigned N_REQ        = 4,
   parameter int unsigned GUARD_CYCLES = DEFAULT_GUARD_CYCLES,
   parameter int unsigned BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_REQ-1:0]             req,
   input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]             gnt,
   output logic [UART_BYTE_W-1:0]       uart_tx_byte,
   output logic                         uart_tx_enable,
   output logic                         uart_rx_enable,
   input  logic                         uart_tx_busy,
   input  logic                         uart_byte_available,
   input  logic [UART_BYTE_W-1:0]       uart_rx_byte,
   output logic [UART_BYTE_W-1:0]       rx_data,
   output logic                         rx_valid,
   output logic                         tx_error
);

   localparam int unsigned PTR_W = $clog2(N_REQ);
   localparam int unsigned CNT_W = cnt_width(GUARD_CYCLES, BUSY_TIMEOUT);

   uart_sched_state_t        state, state_d;
   logic [CNT_W-1:0]         cnt, cnt_d;
   logic [PTR_W-1:0]         rr_ptr, rr_ptr_d;
   logic [PTR_W-1:0]         win_idx, win_idx_d;
   logic [PTR_W-1:0]         rr_next_c;
   logic [N_REQ-1:0]         gnt_d;
   logic [UART_BYTE_W-1:0]   tx_byte_d, rx_data_d, arb_byte_c;
   logic                     tx_enable_d, rx_enable_d, rx_valid_d, tx_error_d;
   logic [N_REQ-1:0]         arb_winner_c;
   logic [PTR_W-1:0]         arb_idx_c;
   logic                     arb_valid_c;

   uart_port_scheduler_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr_arbiter (
      .req      (req),
      .rr_ptr   (rr_ptr),
      .winner_c (arb_winner_c),
      .idx_c    (arb_idx_c),
      .valid_c  (arb_valid_c)
   );

   // Select the winning requester's byte
   always_comb begin
      arb_byte_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (arb_idx_c == PTR_W'(i)) arb_byte_c = req_data[i*UART_BYTE_W +: UART_BYTE_W];
      end
   end

   // Pointer position just after the last served requester
   assign rr_next_c = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         rr_ptr         <= '0;
         win_idx        <= '0;
         gnt            <= '0;
         uart_tx_byte   <= '0;
         uart_tx_enable <= 1'b0;
         uart_rx_enable <= 1'b1;
         rx_data        <= '0;
         rx_valid       <= 1'b0;
         tx_error       <= 1'b0;
      end else begin
         state          <= state_d;
         cnt            <= cnt_d;
         rr_ptr         <= rr_ptr_d;
         win_idx        <= win_idx_d;
         gnt            <= gnt_d;
         uart_tx_byte   <= tx_byte_d;
         uart_tx_enable <= tx_enable_d;
         uart_rx_enable <= rx_enable_d;
         rx_data        <= rx_data_d;
         rx_valid       <= rx_valid_d;
         tx_error       <= tx_error_d;
      end
   end

   // Next-state and next-output logic; RX capture has priority over a grant in IDLE
   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      rr_ptr_d   = rr_ptr;
      win_idx_d  = win_idx;
      gnt_d      = '0;
      tx_byte_d  = uart_tx_byte;
      rx_data_d  = rx_data;
      rx_valid_d = 1'b0;
      tx_error_d = tx_error;
      case (state)
         IDLE: begin
            if (uart_byte_available) begin
               rx_data_d  = uart_rx_byte;
               rx_valid_d = 1'b1;
            end else if (arb_valid_c) begin
               gnt_d     = arb_winner_c;
               tx_byte_d = arb_byte_c;
               win_idx_d = arb_idx_c;
               state_d   = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (uart_tx_busy) begin
               state_d = SEND;
            end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
               tx_error_d = 1'b1;
               cnt_d      = '0;
               rr_ptr_d   = rr_next_c;
               state_d    = GUARD;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         SEND: begin
            if (!uart_tx_busy) begin
               cnt_d    = '0;
               rr_ptr_d = rr_next_c;
               state_d  = GUARD;
            end
         end
         GUARD: begin
            if (cnt == CNT_W'(GUARD_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      tx_enable_d = (state_d == LOAD);
      rx_enable_d = (state_d == IDLE);
   end

endmodule

// File: tb/tb_uart_port_scheduler.sv
// Self-checking bench for uart_port_scheduler with a simple UART core model.
`timescale 1ns/1ps
module tb_uart_port_scheduler;

   localparam int N     = 4;
   localparam int G     = 104;
   localparam int T     = 16;
   localparam int FRAME = 20;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   gnt;
   logic [7:0]     uart_tx_byte;
   logic           uart_tx_enable;
   logic           uart_rx_enable;
   logic           uart_tx_busy;
   logic           uart_byte_available;
   logic [7:0]     uart_rx_byte;
   logic [7:0]     rx_data;
   logic           rx_valid;
   logic           tx_error;

   int         total = 0;
   int         bad = 0;
   int         rr_model = 0;
   logic [7:0] rx_model = 8'h00;
   int         n_txen = 0;
   bit         model_busy_en = 1'b1;

   uart_port_scheduler #(.N_REQ(N), .GUARD_CYCLES(G), .BUSY_TIMEOUT(T)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .req                 (req),
      .req_data            (req_data),
      .gnt                 (gnt),
      .uart_tx_byte        (uart_tx_byte),
      .uart_tx_enable      (uart_tx_enable),
      .uart_rx_enable      (uart_rx_enable),
      .uart_tx_busy        (uart_tx_busy),
      .uart_byte_available (uart_byte_available),
      .uart_rx_byte        (uart_rx_byte),
      .rx_data             (rx_data),
      .rx_valid            (rx_valid),
      .tx_error            (tx_error)
   );

   always #5 clk = ~clk;

   // UART core model: busy for FRAME clocks after each start pulse
   initial begin
      uart_tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (uart_tx_enable && model_busy_en) begin
            uart_tx_busy = 1'b1;
            repeat (FRAME) @(negedge clk);
            uart_tx_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) if (rst_n && uart_tx_enable) n_txen++;

   // Round-robin rule: first requester at or after ptr, wrapping
   function automatic int pick(input logic [N-1:0] r, input int ptr);
      int i;
      for (int k = 0; k < N; k++) begin
         i = (ptr + k) % N;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] byte_of(input logic [8*N-1:0] d, input int i);
      return d[8*i +: 8];
   endfunction

   task automatic wait_gnt(output logic [N-1:0] g, output int cyc, output bit ok);
      ok = 1'b0; g = '0; cyc = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         cyc = c + 1;
         if (gnt != '0) begin
            g = gnt; ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (uart_rx_enable && !uart_tx_busy) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      logic [29:0] got;
      rst_n = 1'b0; req = '0; req_data = '0;
      uart_byte_available = 1'b0; uart_rx_byte = 8'h00;
      repeat (3) @(negedge clk);
      got = {gnt, uart_tx_byte, uart_tx_enable, uart_rx_enable, rx_data, rx_valid, tx_error};
      total++;
      if (got !== {4'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
         bad++; $display("FAIL reset_values: got %h want %h", got, {4'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_all_four();
      logic [N-1:0] g; int cyc, exp, txen0; bit ok;
      wait_idle(ok);
      req_data = {8'h33, 8'h32, 8'h31, 8'h30};
      req = 4'hF;
      txen0 = n_txen;
      for (int k = 0; k < 5; k++) begin
         exp = pick(req, rr_model);
         wait_gnt(g, cyc, ok);
         total++;
         if (!ok || g !== onehot(exp)) begin bad++; $display("FAIL all4_order[%0d]: got %b want %b", k, g, onehot(exp)); end
         total++;
         if (uart_tx_byte !== 8'h30 + 8'(exp)) begin bad++; $display("FAIL all4_byte[%0d]: got %h want %h", k, uart_tx_byte, 8'h30 + 8'(exp)); end
         if (k > 0) begin
            total++;
            if (cyc < G + FRAME || cyc > G + FRAME + 6) begin bad++; $display("FAIL all4_gap[%0d]: got %0d want %0d..%0d", k, cyc, G + FRAME, G + FRAME + 6); end
         end
         rr_model = (exp + 1) % N;
      end
      req = '0;
      wait_idle(ok);
      total++;
      if (n_txen - txen0 !== 5) begin bad++; $display("FAIL all4_txen_count: got %0d want 5", n_txen - txen0); end
   endtask

   task automatic test_single();
      int low, pulses; bit ok;
      wait_idle(ok);
      req_data = $urandom;
      req_data[15:8] = 8'h41;
      req = 4'b0010;
      @(negedge clk);
      total++;
      if (gnt !== 4'b0010) begin bad++; $display("FAIL single_gnt: got %b want 0010", gnt); end
      total++;
      if ({uart_tx_byte, uart_tx_enable, uart_rx_enable} !== {8'h41, 1'b1, 1'b0}) begin
         bad++; $display("FAIL single_load: got byte=%h en=%b rxen=%b want 41 1 0", uart_tx_byte, uart_tx_enable, uart_rx_enable);
      end
      req = '0;
      rr_model = 2;
      low = 1; pulses = 1;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (uart_rx_enable) break;
         low++;
         if (uart_tx_enable) pulses++;
      end
      total++;
      if (pulses !== 1) begin bad++; $display("FAIL single_txen_pulses: got %0d want 1", pulses); end
      total++;
      if (low < G + FRAME || low > G + FRAME + 6) begin bad++; $display("FAIL single_rxen_low: got %0d want %0d..%0d", low, G + FRAME, G + FRAME + 6); end
      total++;
      if (uart_tx_byte !== 8'h41) begin bad++; $display("FAIL single_byte_hold: got %h want 41", uart_tx_byte); end
   endtask

   task automatic test_rx_priority();
      int exp; bit ok;
      wait_idle(ok);
      req = N'($urandom_range(1, 15));
      req_data = $urandom;
      exp = pick(req, rr_model);
      uart_byte_available = 1'b1;
      uart_rx_byte = 8'h5A;
      @(negedge clk);
      total++;
      if ({rx_valid, rx_data, gnt} !== {1'b1, 8'h5A, 4'b0}) begin
         bad++; $display("FAIL rxprio_capture: got v=%b d=%h g=%b want 1 5a 0000", rx_valid, rx_data, gnt);
      end
      uart_byte_available = 1'b0;
      @(negedge clk);
      total++;
      if ({gnt, rx_valid} !== {onehot(exp), 1'b0}) begin
         bad++; $display("FAIL rxprio_delayed_gnt: got g=%b v=%b want %b 0", gnt, rx_valid, onehot(exp));
      end
      rx_model = 8'h5A;
      rr_model = (exp + 1) % N;
      req = '0;
   endtask

   task automatic test_rx_during_send();
      logic [N-1:0] g; int cyc, exp; bit ok, seen;
      wait_idle(ok);
      req = N'($urandom_range(1, 15));
      req_data = $urandom;
      exp = pick(req, rr_model);
      wait_gnt(g, cyc, ok);
      total++;
      if (!ok || g !== onehot(exp)) begin bad++; $display("FAIL rxsend_gnt: got %b want %b", g, onehot(exp)); end
      rr_model = (exp + 1) % N;
      req = '0;
      repeat (5) @(negedge clk);
      uart_byte_available = 1'b1;
      uart_rx_byte = 8'hC3;
      @(negedge clk);
      uart_byte_available = 1'b0;
      seen = rx_valid;
      repeat (4) begin @(negedge clk); seen |= rx_valid; end
      total++;
      if (seen !== 1'b0 || rx_data !== rx_model) begin
         bad++; $display("FAIL rxsend_ignored: got v=%b d=%h want 0 %h", seen, rx_data, rx_model);
      end
   endtask

   task automatic test_timeout();
      logic [N-1:0] g; int cyc, exp, first; bit ok;
      wait_idle(ok);
      model_busy_en = 1'b0;
      req = N'($urandom_range(1, 15));
      req_data = $urandom;
      exp = pick(req, rr_model);
      wait_gnt(g, cyc, ok);
      total++;
      if (!ok || g !== onehot(exp)) begin bad++; $display("FAIL timeout_gnt: got %b want %b", g, onehot(exp)); end
      rr_model = (exp + 1) % N;
      req = '0;
      first = -1;
      for (int c = 1; c <= T + 10; c++) begin
         @(negedge clk);
         if (tx_error && first < 0) first = c;
      end
      total++;
      if (first < T || first > T + 2) begin bad++; $display("FAIL timeout_latency: got %0d want %0d..%0d", first, T, T + 2); end
      wait_idle(ok);
      total++;
      if (!ok || tx_error !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got idle=%b err=%b want 1 1", ok, tx_error); end
      model_busy_en = 1'b1;
      req = 4'hF;
      exp = pick(req, rr_model);
      wait_gnt(g, cyc, ok);
      total++;
      if (!ok || g !== onehot(exp)) begin bad++; $display("FAIL timeout_rr_advance: got %b want %b", g, onehot(exp)); end
      rr_model = (exp + 1) % N;
      req = '0;
   endtask

   task automatic test_random();
      logic [N-1:0] g; int cyc, exp; bit ok;
      wait_idle(ok);
      req = N'($urandom_range(1, 15));
      req_data = $urandom;
      for (int k = 0; k < 20; k++) begin
         exp = pick(req, rr_model);
         wait_gnt(g, cyc, ok);
         total++;
         if (!ok || g !== onehot(exp) || uart_tx_byte !== byte_of(req_data, exp) || uart_tx_enable !== 1'b1) begin
            bad++; $display("FAIL random[%0d]: got g=%b b=%h en=%b want %b %h 1", k, g, uart_tx_byte, uart_tx_enable, onehot(exp), byte_of(req_data, exp));
         end
         rr_model = (exp + 1) % N;
         req = N'($urandom_range(1, 15));
         req_data = $urandom;
      end
      req = '0;
   endtask

   task automatic test_reset_mid_frame();
      logic [N-1:0] g; logic [29:0] got; int cyc, exp; bit ok;
      wait_idle(ok);
      req = 4'hF;
      wait_gnt(g, cyc, ok);
      req = '0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 got = {gnt, uart_tx_byte, uart_tx_enable, uart_rx_enable, rx_data, rx_valid, tx_error};
      total++;
      if (got !== {4'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
         bad++; $display("FAIL midframe_reset: got %h want %h", got, {4'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
      end
      rr_model = 0;
      rx_model = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      req = 4'hF;
      req_data = $urandom;
      exp = pick(req, rr_model);
      @(negedge clk);
      total++;
      if (gnt !== onehot(exp) || uart_tx_byte !== byte_of(req_data, exp)) begin
         bad++; $display("FAIL after_reset_gnt: got g=%b b=%h want %b %h", gnt, uart_tx_byte, onehot(exp), byte_of(req_data, exp));
      end
      req = '0;
      wait_idle(ok);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_all_four();
      test_single();
      test_rx_priority();
      test_rx_during_send();
      test_timeout();
      test_random();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
